// File: rtl/mmio_pkg.sv
// Shared constants for the MEM-stage memory-mapped I/O block: register map,
// status bit positions and board I/O widths.
package mmio_pkg;

  localparam int DBITS = 32;

  localparam logic [DBITS-1:0] ADDR_HEX   = 32'hF000_0000;
  localparam logic [DBITS-1:0] ADDR_LEDR  = 32'hF000_0004;
  localparam logic [DBITS-1:0] ADDR_KDATA = 32'hF000_0010;
  localparam logic [DBITS-1:0] ADDR_SDATA = 32'hF000_0014;
  localparam logic [DBITS-1:0] ADDR_KCTRL = 32'hF000_0110;
  localparam logic [DBITS-1:0] ADDR_SCTRL = 32'hF000_0114;

  localparam int READY_BIT   = 0;
  localparam int OVERRUN_BIT = 2;

  localparam int HEX_W  = 16;
  localparam int LEDR_W = 10;
  localparam int KEY_W  = 4;
  localparam int SW_W   = 10;

  function automatic logic [DBITS-1:0] status_word(input logic rdy, input logic ovr);
    logic [DBITS-1:0] w;
    w              = '0;
    w[READY_BIT]   = rdy;
    w[OVERRUN_BIT] = ovr;
    return w;
  endfunction

endpackage

// File: rtl/mmio_controller_if.sv
// CPU-side bus between the MEM stage and the I/O block: address, strobes,
// store data, and the combinational read data / select flag back.
interface mmio_controller_if;
  logic [mmio_pkg::DBITS-1:0] addr;
  logic                       wr_en;
  logic                       rd_en;
  logic [mmio_pkg::DBITS-1:0] wr_data;
  logic [mmio_pkg::DBITS-1:0] rd_data;
  logic                       io_sel;

  modport master (output addr, wr_en, rd_en, wr_data, input rd_data, io_sel);
  modport slave  (input addr, wr_en, rd_en, wr_data, output rd_data, io_sel);
endinterface

// File: rtl/mmio_debounce.sv
// Two-flop synchronizer plus stability filter: o_stable follows i_raw only
// after the synchronized value holds for DEBOUNCE_CYCLES consecutive cycles.
module mmio_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable,
  output logic             o_changed
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync_m;
  logic [WIDTH-1:0] r_sync_s;
  logic [WIDTH-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_stable;
  logic             w_accept;

  // High in the cycle whose closing edge moves the candidate into o_stable.
  assign w_accept  = (r_cnt == CNT_MAX) && (r_cand != r_stable);
  assign o_changed = w_accept;
  assign o_stable  = r_stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_m <= '0;
      r_sync_s <= '0;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      r_sync_m <= i_raw;
      r_sync_s <= r_sync_m;
      if (r_sync_s != r_cand) begin
        r_cand <= r_sync_s;
        r_cnt  <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) r_stable <= r_cand;
    end
  end

endmodule

// File: rtl/mmio_controller.sv
// MEM-stage I/O block: HEX/LEDR output registers, KEY/SW input registers
// with ready/overrun status, and the I/O read mux with its select flag.
module mmio_controller
  import mmio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mmio_controller_if.slave   bus,
  input  logic [KEY_W-1:0]   i_key,
  input  logic [SW_W-1:0]    i_sw,
  output logic [HEX_W-1:0]   o_hex,
  output logic [LEDR_W-1:0]  o_ledr
);

  logic [KEY_W-1:0]  r_key_m, r_key_s, r_key_prev, r_kdata;
  logic              r_krdy, r_kovr, r_srdy, r_sovr;
  logic [HEX_W-1:0]  r_hex;
  logic [LEDR_W-1:0] r_ledr;
  logic [SW_W-1:0]   w_sdata;
  logic              w_sevt, w_kevt;
  logic              w_kcons, w_scons, w_kclr, w_sclr;
  logic              w_unused;

  mmio_debounce #(.WIDTH(SW_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raw     (i_sw),
    .o_stable  (w_sdata),
    .o_changed (w_sevt)
  );

  assign w_kevt   = (r_key_s != r_key_prev);
  assign w_kcons  = bus.rd_en && (bus.addr == ADDR_KDATA);
  assign w_scons  = bus.rd_en && (bus.addr == ADDR_SDATA);
  assign w_kclr   = bus.wr_en && (bus.addr == ADDR_KCTRL) && !bus.wr_data[OVERRUN_BIT];
  assign w_sclr   = bus.wr_en && (bus.addr == ADDR_SCTRL) && !bus.wr_data[OVERRUN_BIT];
  assign w_unused = &{1'b0, bus.wr_data[DBITS-1:HEX_W]};
  assign o_hex    = r_hex;
  assign o_ledr   = r_ledr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_m    <= '0;
      r_key_s    <= '0;
      r_key_prev <= '0;
      r_kdata    <= '0;
      r_krdy     <= 1'b0;
      r_kovr     <= 1'b0;
      r_srdy     <= 1'b0;
      r_sovr     <= 1'b0;
      r_hex      <= '0;
      r_ledr     <= '0;
    end else begin
      r_key_m    <= i_key;
      r_key_s    <= r_key_m;
      r_key_prev <= r_key_s;
      if (bus.wr_en && bus.addr == ADDR_HEX)  r_hex  <= bus.wr_data[HEX_W-1:0];
      if (bus.wr_en && bus.addr == ADDR_LEDR) r_ledr <= bus.wr_data[LEDR_W-1:0];

      // A data event keeps ready high even when the same cycle consumes it.
      if (w_kevt) begin
        r_kdata <= r_key_s;
        r_krdy  <= 1'b1;
      end else if (w_kcons) begin
        r_krdy <= 1'b0;
      end
      if (w_kevt && r_krdy && !w_kcons) r_kovr <= 1'b1;
      else if (w_kclr)                  r_kovr <= 1'b0;

      if (w_sevt)       r_srdy <= 1'b1;
      else if (w_scons) r_srdy <= 1'b0;
      if (w_sevt && r_srdy && !w_scons) r_sovr <= 1'b1;
      else if (w_sclr)                  r_sovr <= 1'b0;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.io_sel  = 1'b1;
    case (bus.addr)
      ADDR_HEX:   bus.rd_data = DBITS'(r_hex);
      ADDR_LEDR:  bus.rd_data = DBITS'(r_ledr);
      ADDR_KDATA: bus.rd_data = DBITS'(r_kdata);
      ADDR_SDATA: bus.rd_data = DBITS'(w_sdata);
      ADDR_KCTRL: bus.rd_data = status_word(r_krdy, r_kovr);
      ADDR_SCTRL: bus.rd_data = status_word(r_srdy, r_sovr);
      default:    bus.io_sel  = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mmio_controller.sv
// Bench for mmio_controller: directed scenarios plus a randomized run checked
// against a history-window reference model of the register map.
module tb_mmio_controller;
  import mmio_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key = '0;
  logic [9:0]  sw = '0;
  logic [15:0] hex;
  logic [9:0]  ledr;

  mmio_controller_if bus();

  mmio_controller #(.DEBOUNCE_CYCLES(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .i_key  (key),
    .i_sw   (sw),
    .o_hex  (hex),
    .o_ledr (ledr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register values plus raw input samples taken at each edge.
  logic [15:0] m_hex;
  logic [9:0]  m_ledr, m_sdata;
  logic [3:0]  m_kdata;
  logic        m_krdy, m_kovr, m_srdy, m_sovr;
  logic [3:0]  kh [1:3];
  logic [9:0]  sh [1:N+2];

  task automatic model_reset();
    m_hex = '0; m_ledr = '0; m_sdata = '0; m_kdata = '0;
    m_krdy = 0; m_kovr = 0; m_srdy = 0; m_sovr = 0;
    for (int i = 1; i <= 3; i++) kh[i] = '0;
    for (int i = 1; i <= N + 2; i++) sh[i] = '0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    case (a)
      ADDR_HEX:   return 32'(m_hex);
      ADDR_LEDR:  return 32'(m_ledr);
      ADDR_KDATA: return 32'(m_kdata);
      ADDR_SDATA: return 32'(m_sdata);
      ADDR_KCTRL: return {29'b0, m_kovr, 1'b0, m_krdy};
      ADDR_SCTRL: return {29'b0, m_sovr, 1'b0, m_srdy};
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic exp_sel(input logic [31:0] a);
    return (a == ADDR_HEX) || (a == ADDR_LEDR) || (a == ADDR_KDATA) ||
           (a == ADDR_SDATA) || (a == ADDR_KCTRL) || (a == ADDR_SCTRL);
  endfunction

  task automatic set_bus(input logic [31:0] a, input logic w, input logic r, input logic [31:0] d);
    bus.addr = a; bus.wr_en = w; bus.rd_en = r; bus.wr_data = d;
  endtask

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic tick();
    logic kev, sev, kcons, scons;
    if (!rst_n) begin
      model_reset();
    end else begin
      // Key seen two edges late; an event is a change between consecutive synced samples.
      kev = (kh[2] != kh[3]);
      // Switch value accepted once the last N synced samples agree and differ from SDATA.
      sev = (sh[3] != m_sdata);
      for (int i = 4; i <= N + 2; i++) if (sh[i] != sh[3]) sev = 0;
      kcons = bus.rd_en && (bus.addr == ADDR_KDATA);
      scons = bus.rd_en && (bus.addr == ADDR_SDATA);
      if (bus.wr_en && bus.addr == ADDR_KCTRL && !bus.wr_data[2]) m_kovr = 0;
      if (bus.wr_en && bus.addr == ADDR_SCTRL && !bus.wr_data[2]) m_sovr = 0;
      if (kev) begin
        if (m_krdy && !kcons) m_kovr = 1;
        m_kdata = kh[2];
        m_krdy  = 1;
      end else if (kcons) m_krdy = 0;
      if (sev) begin
        if (m_srdy && !scons) m_sovr = 1;
        m_sdata = sh[3];
        m_srdy  = 1;
      end else if (scons) m_srdy = 0;
      if (bus.wr_en && bus.addr == ADDR_HEX)  m_hex  = bus.wr_data[15:0];
      if (bus.wr_en && bus.addr == ADDR_LEDR) m_ledr = bus.wr_data[9:0];
      for (int i = 3; i >= 2; i--) kh[i] = kh[i-1];
      kh[1] = key;
      for (int i = N + 2; i >= 2; i--) sh[i] = sh[i-1];
      sh[1] = sw;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] addrs [6];
    addrs = '{ADDR_HEX, ADDR_LEDR, ADDR_KDATA, ADDR_SDATA, ADDR_KCTRL, ADDR_SCTRL};
    model_reset();
    set_bus(32'h0, 0, 0, 32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (hex !== 16'h0 || ledr !== 10'h0) begin
      errors++; $display("FAIL reset_outputs: hex=%h ledr=%h required 0", hex, ledr);
    end
    foreach (addrs[i]) begin
      set_bus(addrs[i], 0, 0, 32'h0);
      #1;
      checks++;
      if (bus.rd_data !== 32'h0 || bus.io_sel !== 1'b1) begin
        errors++; $display("FAIL reset_reg %h: rd_data=%h io_sel=%b required 0/1", addrs[i], bus.rd_data, bus.io_sel);
      end
    end
    @(negedge clk);
    set_bus(32'h0, 0, 0, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_hex();
    set_bus(ADDR_HEX, 1, 0, 32'h0000BEEF);
    tick();
    set_bus(ADDR_HEX, 0, 1, 32'h0);
    #1;
    checks++;
    if (hex !== 16'hBEEF || bus.rd_data !== 32'h0000BEEF || bus.io_sel !== 1'b1) begin
      errors++; $display("FAIL hex_rw: hex=%h rd=%h sel=%b required BEEF/0000BEEF/1", hex, bus.rd_data, bus.io_sel);
    end
    tick();
  endtask

  task automatic test_ledr_unmapped();
    set_bus(ADDR_LEDR, 1, 0, 32'hFFFFFFFF);
    tick();
    set_bus(32'h12345678, 0, 1, 32'h0);
    #1;
    checks++;
    if (ledr !== 10'h3FF) begin
      errors++; $display("FAIL ledr_write: ledr=%h required 3ff", ledr);
    end
    checks++;
    if (bus.rd_data !== 32'h0 || bus.io_sel !== 1'b0) begin
      errors++; $display("FAIL unmapped_read: rd=%h sel=%b required 0/0", bus.rd_data, bus.io_sel);
    end
    tick();
    set_bus(32'h0, 0, 0, 32'h0);
  endtask

  task automatic test_key_ready();
    key = 4'b0010;
    repeat (3) tick();
    set_bus(ADDR_KDATA, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h2) begin
      errors++; $display("FAIL key_data: rd=%h required 2", bus.rd_data);
    end
    set_bus(ADDR_KCTRL, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h1) begin
      errors++; $display("FAIL key_ready: kctrl=%h required 1", bus.rd_data);
    end
    set_bus(ADDR_KDATA, 0, 1, 32'h0);
    tick();
    set_bus(ADDR_KCTRL, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h0) begin
      errors++; $display("FAIL key_consume: kctrl=%h required 0", bus.rd_data);
    end
  endtask

  task automatic test_key_overrun();
    set_bus(32'h0, 0, 0, 32'h0);
    key = 4'b0001;
    tick();
    key = 4'b0011;
    repeat (4) tick();
    set_bus(ADDR_KCTRL, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h5) begin
      errors++; $display("FAIL key_overrun: kctrl=%h required 5", bus.rd_data);
    end
    set_bus(ADDR_KDATA, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h3) begin
      errors++; $display("FAIL key_overwrite: kdata=%h required 3", bus.rd_data);
    end
    set_bus(ADDR_KCTRL, 1, 0, 32'h0);
    tick();
    set_bus(ADDR_KCTRL, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h1) begin
      errors++; $display("FAIL key_ovr_clear: kctrl=%h required 1", bus.rd_data);
    end
    set_bus(ADDR_KDATA, 0, 1, 32'h0);
    tick();
    set_bus(32'h0, 0, 0, 32'h0);
  endtask

  task automatic test_sw_debounce();
    sw = 10'h155;
    repeat (3) tick();
    sw = 10'h000;
    repeat (10) tick();
    set_bus(ADDR_SDATA, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h0) begin
      errors++; $display("FAIL sw_glitch_data: sdata=%h required 0", bus.rd_data);
    end
    set_bus(ADDR_SCTRL, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h0) begin
      errors++; $display("FAIL sw_glitch_ready: sctrl=%h required 0", bus.rd_data);
    end
    sw = 10'h155;
    repeat (10) tick();
    set_bus(ADDR_SDATA, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h155) begin
      errors++; $display("FAIL sw_stable_data: sdata=%h required 155", bus.rd_data);
    end
    set_bus(ADDR_SCTRL, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h1) begin
      errors++; $display("FAIL sw_stable_ready: sctrl=%h required 1", bus.rd_data);
    end
    set_bus(ADDR_SDATA, 0, 1, 32'h0);
    tick();
    set_bus(ADDR_SCTRL, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h0) begin
      errors++; $display("FAIL sw_consume: sctrl=%h required 0", bus.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    set_bus(32'h0, 0, 0, 32'h0);
    key = 4'b0100;
    repeat (3) tick();
    key = 4'b1000;
    repeat (2) tick();
    set_bus(ADDR_KDATA, 0, 1, 32'h0);
    tick();
    set_bus(ADDR_KDATA, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h8) begin
      errors++; $display("FAIL collide_data: kdata=%h required 8", bus.rd_data);
    end
    set_bus(ADDR_KCTRL, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h1) begin
      errors++; $display("FAIL collide_status: kctrl=%h required 1", bus.rd_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] maps [6];
    int          pick;
    maps = '{ADDR_HEX, ADDR_LEDR, ADDR_KDATA, ADDR_SDATA, ADDR_KCTRL, ADDR_SCTRL};
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0)  key = 4'($urandom);
      if ($urandom_range(0, 11) == 0) sw  = 10'($urandom);
      pick = int'($urandom_range(0, 7));
      set_bus((pick < 6) ? maps[pick] : $urandom,
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), $urandom);
      #1;
      checks++;
      if (bus.rd_data !== exp_rd(bus.addr) || bus.io_sel !== exp_sel(bus.addr)) begin
        errors++; $display("FAIL rand_read cyc %0d addr %h: rd=%h sel=%b required %h/%b",
                           c, bus.addr, bus.rd_data, bus.io_sel, exp_rd(bus.addr), exp_sel(bus.addr));
      end
      checks++;
      if (hex !== m_hex || ledr !== m_ledr) begin
        errors++; $display("FAIL rand_outputs cyc %0d: hex=%h ledr=%h required %h/%h", c, hex, ledr, m_hex, m_ledr);
      end
      tick();
    end
    set_bus(32'h0, 0, 0, 32'h0);
  endtask

  task automatic test_reset_mid_debounce();
    set_bus(ADDR_HEX, 1, 0, 32'h00001234);
    tick();
    set_bus(ADDR_LEDR, 1, 0, 32'h000002AA);
    tick();
    set_bus(32'h0, 0, 0, 32'h0);
    key = 4'b0110;
    sw  = 10'h2AA;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    set_bus(ADDR_KDATA, 0, 0, 32'h0);
    #1;
    checks++;
    if (hex !== 16'h0 || ledr !== 10'h0 || bus.rd_data !== 32'h0) begin
      errors++; $display("FAIL mid_reset: hex=%h ledr=%h kdata=%h required 0", hex, ledr, bus.rd_data);
    end
    key = 4'b0000;
    sw  = 10'h000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) tick();
    set_bus(ADDR_SDATA, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h0) begin
      errors++; $display("FAIL stale_sw_data: sdata=%h required 0", bus.rd_data);
    end
    set_bus(ADDR_SCTRL, 0, 0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data !== 32'h0) begin
      errors++; $display("FAIL stale_sw_ready: sctrl=%h required 0", bus.rd_data);
    end
  endtask

  initial begin
    set_bus(32'h0, 0, 0, 32'h0);
    test_reset();
    test_hex();
    test_ledr_unmapped();
    test_key_ready();
    test_key_overrun();
    test_sw_debounce();
    test_back_to_back();
    test_random();
    test_reset_mid_debounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
